// File: rtl/grayscale.sv
// RGB-to-grayscale converter between a show-ahead RGB FIFO and an 8-bit pixel FIFO.
// Define GRAYSCALE_BT601_EN for BT.601 luma weights; default is the plain (R+G+B)/3 average.
module grayscale #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic        clock,
    input  logic        reset,
    output logic        in_rd_en,
    input  logic        in_empty,
    input  logic [23:0] in_dout,
    output logic        out_wr_en,
    input  logic        out_full,
    output logic [7:0]  out_din,
    output logic        frame_done
);

    typedef enum logic {
        S_READ,
        S_WRITE
    } state_t;

    localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
    localparam logic [10:0] Y_LAST = 11'(HEIGHT - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [10:0] r_xCnt;
    logic [10:0] r_yCnt;
    logic [7:0]  r_gray;
    logic        r_lastPix;

    logic [7:0]  w_red;
    logic [7:0]  w_green;
    logic [7:0]  w_blue;
    logic [7:0]  w_gray;
    logic        w_pop;
    logic        w_xLast;
    logic        w_yLast;

    assign w_red   = in_dout[23:16];
    assign w_green = in_dout[15:8];
    assign w_blue  = in_dout[7:0];

`ifdef GRAYSCALE_BT601_EN
    // Weights sum to 256, so the 16-bit intermediate cannot overflow for 8-bit inputs.
    logic [15:0] w_weighted;
    assign w_weighted = (16'(w_red)   * 16'd77)
                      + (16'(w_green) * 16'd150)
                      + (16'(w_blue)  * 16'd29);
    assign w_gray     = 8'(w_weighted >> 8);
`else
    logic [9:0] w_sum;
    assign w_sum  = 10'(w_red) + 10'(w_green) + 10'(w_blue);
    assign w_gray = 8'(w_sum / 10'd3);
`endif

    assign w_xLast = (r_xCnt == X_LAST);
    assign w_yLast = (r_yCnt == Y_LAST);

    always_comb begin
        w_nextState = r_state;
        in_rd_en    = 1'b0;
        out_wr_en   = 1'b0;
        case (r_state)
            S_READ: begin
                if (!in_empty) begin
                    in_rd_en    = 1'b1;
                    w_nextState = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!out_full) begin
                    out_wr_en   = 1'b1;
                    w_nextState = S_READ;
                end
            end
        endcase
    end

    assign w_pop = in_rd_en;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_READ;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The last-pixel tag travels with the held pixel so a long out_full stall cannot lose it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_xCnt    <= '0;
            r_yCnt    <= '0;
            r_gray    <= '0;
            r_lastPix <= 1'b0;
        end else if (w_pop) begin
            r_gray    <= w_gray;
            r_lastPix <= w_xLast && w_yLast;
            if (w_xLast) begin
                r_xCnt <= '0;
                r_yCnt <= w_yLast ? 11'd0 : r_yCnt + 11'd1;
            end else begin
                r_xCnt <= r_xCnt + 11'd1;
            end
        end
    end

    assign out_din    = r_gray;
    assign frame_done = out_wr_en && r_lastPix;

endmodule

// File: doc/grayscale.md
GRAYSCALE -- requirements
Module: grayscale

Interface
REQ-001 WIDTH, default 720, pixels per line.
REQ-002 HEIGHT, default 540, lines per frame.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_rd_en  output  1  pop request to upstream show-ahead RGB FIFO.
REQ-006 in_empty  input  1  upstream FIFO empty.
REQ-007 in_dout  input  24  RGB pixel; [23:16]=R, [15:8]=G, [7:0]=B; valid while in_empty low, before pop.
REQ-008 out_wr_en  output  1  push strobe to downstream 8-bit pixel FIFO feeding the edge-detect stage.
REQ-009 out_full  input  1  downstream FIFO full.
REQ-010 out_din  output  8  grayscale pixel.
REQ-011 frame_done  output  1  one-cycle pulse on the push of the last pixel of a frame.

Function
REQ-012 Two-state FSM SHALL be used: S_READ, S_WRITE; reset state S_READ.
REQ-013 S_READ: when in_empty low, SHALL assert in_rd_en for exactly one cycle, register gray result into gray_reg, advance counters, go to S_WRITE; otherwise hold, in_rd_en low.
REQ-014 S_WRITE: when out_full low, SHALL assert out_wr_en for exactly one cycle, go to S_READ; otherwise hold with out_wr_en low and gray_reg unchanged.
REQ-015 in_rd_en and out_wr_en SHALL never be high in the same cycle; in_rd_en SHALL never be high while in_empty high; out_wr_en never high while out_full high.
REQ-016 out_din SHALL equal gray_reg at all times (registered, stable during backpressure).
REQ-017 Latency: pixel popped in cycle N SHALL be pushed no earlier than cycle N+1; peak throughput one pixel per 2 cycles.
REQ-018 Default arithmetic: gray = (R+G+B)/3, 10-bit unsigned sum, integer division truncating toward zero, result fits 8 bits without saturation.
REQ-019 x_cnt (11 bits) SHALL increment per pop; at WIDTH-1 wrap to 0 and increment y_cnt; y_cnt at HEIGHT-1 with x_cnt WIDTH-1 SHALL wrap both to 0.
REQ-020 Pixel pushed for (x=WIDTH-1, y=HEIGHT-1) SHALL set frame_done high in the same cycle as its out_wr_en; frame_done low otherwise.
REQ-021 A last_pix flag SHALL be captured at pop time so frame_done is correct regardless of out_full stall length.
REQ-022 Back-to-back frames SHALL proceed with no idle cycles beyond the normal FSM rhythm.

Reset
REQ-023 On reset: state S_READ, x_cnt 0, y_cnt 0, gray_reg 0, last_pix 0; in_rd_en 0, out_wr_en 0, out_din 0, frame_done 0.
REQ-024 Reset asserted mid-frame SHALL discard any held pixel (no push after release) and restart at pixel (0,0).
REQ-025 First pop SHALL occur no earlier than the first rising edge after reset deassertion with in_empty low.

Configuration
REQ-026 Macro GRAYSCALE_BT601_EN: when defined, gray = (77*R + 150*G + 29*B) >> 8 using 16-bit unsigned intermediate, truncated; when undefined, REQ-018 average applies. Timing, handshake and counters SHALL be identical in both builds.

Verification
REQ-027 Reset, feed (255,255,255) then (30,60,90) then (10,20,31) -> outputs 255, 60, 20 (default); with GRAYSCALE_BT601_EN -> 255, 54, 18.
REQ-028 One pixel (90,90,90) with out_full high 5 cycles after pop -> out_wr_en low 5 cycles, out_din=90 stable, no second pop, push on cycle out_full drops.
REQ-029 WIDTH=4, HEIGHT=2, 16 continuous pixels, out_full low -> 16 pushes, frame_done high exactly on push 8 and push 16, counters back to (0,0).
REQ-030 in_empty toggled randomly over 100 pixels -> push order and values match reference model, no pop while empty, no pop/push overlap.
REQ-031 Reset asserted in S_WRITE while out_full high, then released -> no stale push, out_din 0, next frame_done after WIDTH*HEIGHT new pixels.
